// File: rtl/mem_bus_master.sv
// Load/store bus initiator for the byte-addressed RAM on a shared tri-state data bus.
// Define MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of issuing them.
module mem_bus_master #(
    parameter int ADDR_WIDTH = 12,
    parameter int READ_WAIT  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_fault,
    output logic                  bus_write,
    output logic                  bus_read,
    output logic [1:0]            bus_data_size,
    output logic [ADDR_WIDTH-1:0] bus_address,
    inout  wire  [31:0]           bus_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic                  write_q, write_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  bus_write_q, bus_write_d;
    logic                  bus_read_q, bus_read_d;
    logic [1:0]            size_q, size_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  fault_q, fault_d;
    logic [3:0]            cnt_q, cnt_d;

    logic       req_legal;
    logic       req_misalign;
    logic [1:0] req_size;

    always_comb begin
        req_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !req_write;
            default:                req_legal = 1'b0;
        endcase
    end

    assign req_size = (req_funct3[1:0] == 2'b10) ? 2'b11 : {1'b0, req_funct3[0]};

`ifdef MISALIGN_TRAP_EN
    assign req_misalign = (req_funct3[1:0] == 2'b01 && req_address[0])
                       || (req_funct3[1:0] == 2'b10 && req_address[1:0] != 2'b00);
`else
    assign req_misalign = 1'b0;
`endif

    // RAM returns the addressed bytes right-aligned on the bus
    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  extend = {{24{d[7]}}, d[7:0]};
            3'b100:  extend = {24'd0, d[7:0]};
            3'b001:  extend = {{16{d[15]}}, d[15:0]};
            3'b101:  extend = {16'd0, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        bus_write_d  = bus_write_q;
        bus_read_d   = bus_read_q;
        size_d       = size_q;
        addr_d       = addr_q;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;
        fault_d      = fault_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    wdata_d  = req_wdata;
                    if (!req_legal || req_misalign) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        fault_d      = 1'b1;
                        rdata_d      = 32'd0;
                    end else begin
                        state_d     = ACCESS;
                        addr_d      = req_address;
                        size_d      = req_size;
                        bus_write_d = req_write;
                        bus_read_d  = !req_write;
                    end
                end
            end
            ACCESS: begin
                if (write_q) begin
                    bus_write_d  = 1'b0;
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    fault_d      = 1'b0;
                    rdata_d      = 32'd0;
                end else if (READ_WAIT == 0) begin
                    bus_read_d   = 1'b0;
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    fault_d      = 1'b0;
                    rdata_d      = extend(funct3_q, bus_data);
                end else begin
                    cnt_d   = 4'(READ_WAIT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    bus_read_d   = 1'b0;
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    fault_d      = 1'b0;
                    rdata_d      = extend(funct3_q, bus_data);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                rdata_d = 32'd0;
                fault_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            funct3_q     <= 3'd0;
            wdata_q      <= 32'd0;
            bus_write_q  <= 1'b0;
            bus_read_q   <= 1'b0;
            size_q       <= 2'd0;
            addr_q       <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'd0;
            fault_q      <= 1'b0;
            cnt_q        <= 4'd0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            bus_write_q  <= bus_write_d;
            bus_read_q   <= bus_read_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            fault_q      <= fault_d;
            cnt_q        <= cnt_d;
        end
    end

    assign req_ready     = (state_q == IDLE) && !reset;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = rdata_q;
    assign resp_fault    = fault_q;
    assign bus_write     = bus_write_q;
    assign bus_read      = bus_read_q;
    assign bus_data_size = size_q;
    assign bus_address   = addr_q;
    // Reset clears bus_write_q asynchronously, so the bus is released at once
    assign bus_data      = bus_write_q ? wdata_q : 32'hzzzz_zzzz;

endmodule
